// File: rtl/pcs_blk_pkg.sv
// 64b/66b block constants and classification helpers shared by the PCS TX/RX
// block-path logic.
package pcs_blk_pkg;

    typedef logic [65:0] blk_t;

    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam logic [7:0] BT_START  = 8'h78;

    localparam blk_t IDLE_BLK = {2'b10, 64'h000000000000001E};
    localparam blk_t ERR_BLK  = {2'b10, 56'h3C78F1E3C78F1E, 8'h1E};

    function automatic logic is_start(input blk_t blk);
        return (blk[65:64] == SYNC_CTRL) && (blk[7:0] == BT_START);
    endfunction

    function automatic logic is_term(input blk_t blk);
        return (blk[65:64] == SYNC_CTRL) &&
               (blk[7:0] inside {8'h87, 8'h99, 8'hAA, 8'hB4,
                                 8'hCC, 8'hD2, 8'hE1, 8'hFF});
    endfunction

endpackage

// File: rtl/tx_frame_sched_rr_pick.sv
// Round-robin first-one finder: searches req_i upward from ptr_i with wrap.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic          vld_o
);

    logic [PW-1:0] idx;

    always_comb begin
        pick_o = '0;
        vld_o  = 1'b0;
        idx    = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = PW'((32'(ptr_i) + off) % N);
            if (!vld_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                vld_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_sched.sv
// Frame-level scheduler onto the PCS TX block path: whole-frame grants with
// round-robin between frames, IDLE fill, orphan drop and stall-timeout flush.
module tx_frame_sched
    import pcs_blk_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned MAX_STALL = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [66*N_REQ-1:0] in_dat,
    input  logic [N_REQ-1:0]  in_vld,
    output logic [N_REQ-1:0]  in_rdy,
    output logic [65:0]       out_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [N_REQ-1:0]  grant,
    output logic              err_drop,
    output logic              err_timeout
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SW = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_FLUSH} state_e;

    state_e           state_q;
    logic [PW-1:0]    rr_ptr_q, owner_q, pick_idx, rr_next;
    logic [SW-1:0]    stall_q;
    blk_t             out_dat_q;
    logic             out_vld_q;
    logic [N_REQ-1:0] grant_q;
    logic             err_drop_q, err_timeout_q;

    blk_t             blk [N_REQ];
    blk_t             own_blk;
    logic [N_REQ-1:0] start_vec, orphan_vec, pick;
    logic             pick_vld, slot_free, stall_hit, own_vld, own_term;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req_i  (start_vec),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick),
        .vld_o  (pick_vld)
    );

    always_comb begin
        slot_free  = !out_vld_q || out_rdy;
        stall_hit  = (stall_q == SW'(MAX_STALL));
        start_vec  = '0;
        orphan_vec = '0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            blk[i]        = in_dat[66*i +: 66];
            start_vec[i]  = in_vld[i] && is_start(blk[i]);
            orphan_vec[i] = in_vld[i] && !is_start(blk[i]);
            if (pick[i]) pick_idx = PW'(i);
        end
        own_blk  = blk[owner_q];
        own_vld  = in_vld[owner_q];
        own_term = is_term(own_blk);
        rr_next  = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);

        // A timed-out slot emits ERR_BLK instead of accepting the owner's block.
        in_rdy = '0;
        unique case (state_q)
            S_IDLE:  if (slot_free) in_rdy = orphan_vec | pick;
            S_FRAME: if (slot_free && !stall_hit) in_rdy[owner_q] = 1'b1;
            S_FLUSH: in_rdy[owner_q] = 1'b1;
            default: in_rdy = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            stall_q       <= '0;
            out_dat_q     <= '0;
            out_vld_q     <= 1'b0;
            grant_q       <= '0;
            err_drop_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            err_drop_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (slot_free) begin
                    err_drop_q <= |orphan_vec;
                    out_vld_q  <= 1'b1;
                    if (pick_vld) begin
                        out_dat_q <= blk[pick_idx];
                        grant_q   <= pick;
                        owner_q   <= pick_idx;
                        stall_q   <= '0;
                        state_q   <= S_FRAME;
                    end else begin
                        out_dat_q <= IDLE_BLK;
                    end
                end
                S_FRAME: if (slot_free) begin
                    if (stall_hit) begin
                        out_dat_q     <= ERR_BLK;
                        out_vld_q     <= 1'b1;
                        err_timeout_q <= 1'b1;
                        state_q       <= S_FLUSH;
                    end else if (own_vld) begin
                        out_dat_q <= own_blk;
                        out_vld_q <= 1'b1;
                        stall_q   <= '0;
                        if (own_term) begin
                            state_q  <= S_IDLE;
                            rr_ptr_q <= rr_next;
                            grant_q  <= '0;
                        end
                    end else begin
                        out_vld_q <= 1'b0;
                        stall_q   <= stall_q + SW'(1);
                    end
                end
                S_FLUSH: begin
                    if (slot_free) begin
                        out_dat_q <= IDLE_BLK;
                        out_vld_q <= 1'b1;
                    end
                    if (own_vld && own_term) begin
                        state_q  <= S_IDLE;
                        rr_ptr_q <= rr_next;
                        grant_q  <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_dat     = out_dat_q;
    assign out_vld     = out_vld_q;
    assign grant       = grant_q;
    assign err_drop    = err_drop_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
- Frame-level scheduler between N_REQ 64b/66b block sources and the single PCS TX block path (ahead of scrambler/gearbox).
- Grants the path to one requester for a whole frame, from start block to terminate block. Round-robin between frames.
- Fills every free output slot outside a frame with IDLE blocks.
- Polices frame sequencing: drops orphan blocks; on mid-frame stall timeout, emits an ERROR block and flushes the rest of that frame.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- MAX_STALL, 16, consecutive empty in-frame slots before timeout (1..255).

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous, active-low reset
- in_dat  in  66*N_REQ  requester blocks; requester i in bits [66*i+65:66*i], {sync[1:0], payload[63:0]}, type byte = payload[7:0]
- in_vld  in  N_REQ  per-requester valid
- in_rdy  out  N_REQ  per-requester ready (combinational)
- out_dat  out  66  scheduled block (registered)
- out_vld  out  1  output valid (registered)
- out_rdy  in  1  downstream ready
- grant  out  N_REQ  one-hot current owner; 0 in S_IDLE (registered)
- err_drop  out  1  1-cycle pulse: orphan block discarded
- err_timeout  out  1  1-cycle pulse: stall timeout, ERROR block emitted

Behaviour:
- Block classification:
  - start = sync 2'b10 and type 0x78.
  - term = sync 2'b10 and type in {0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF}.
  - Any other block is a body block.
- Constants:
  - IDLE_BLK = {2'b10, 64'h000000000000001E}.
  - ERR_BLK = {2'b10, 56'h3C78F1E3C78F1E, 8'h1E}.
- Slot free = !out_vld || out_rdy. The output register loads only when the slot is free; otherwise out_dat and out_vld hold and all in_rdy are 0.
- Reset values: out_dat=0, out_vld=0, grant=0, err_drop=0, err_timeout=0, state=S_IDLE, rr_ptr=0, stall_cnt=0. Reset asserted mid-frame abandons the frame with no ERROR block.
- S_IDLE, each free slot:
  - Candidates are requesters with in_vld=1 and a start block. Search them from rr_ptr upward with wrap; the first hit wins.
  - Winner: in_rdy=1, its block is loaded, grant is set, go to S_FRAME.
  - No candidate: IDLE_BLK is loaded with out_vld=1.
  - Every other requester with in_vld=1 and a non-start block gets in_rdy=1 and its block is discarded. err_drop pulses once per cycle in which any block is discarded.
  - Losing start-block requesters get in_rdy=0.
- S_FRAME (owner g), each free slot:
  - If in_vld[g]=1: in_rdy[g]=1, the block is loaded, stall_cnt is cleared. A term block ends the frame: go to S_IDLE, rr_ptr = (g+1) mod N_REQ, grant=0 on the same edge.
  - If in_vld[g]=0: out_vld=0 (bubble) and stall_cnt increments.
  - When stall_cnt reaches MAX_STALL, that slot loads ERR_BLK with out_vld=1, err_timeout pulses, go to S_FLUSH.
  - Start blocks mid-frame are passed unchecked.
  - Non-owners have in_rdy=0.
- S_FLUSH (owner g):
  - in_rdy[g]=1 every cycle, independent of the slot; owner blocks are discarded.
  - Free slots load IDLE_BLK.
  - When a term block is consumed: go to S_IDLE, rr_ptr = (g+1) mod N_REQ, grant=0.
- Latency: accepted block appears on out_dat on the next clk edge (1 cycle).
- Throughput: 1 block/cycle while out_rdy=1.
- After the first post-reset cycle, out_vld=1 every cycle except in-frame bubbles.
- stall_cnt width = $clog2(MAX_STALL+1); it never wraps.
- Blocks the scheduler does not discard are never duplicated or reordered.

Decomposition:
- Shared package pcs_blk_pkg:
  - IDLE_BLK, ERR_BLK, BT_START=8'h78, the terminate type list.
  - Functions is_start(blk) and is_term(blk) for reuse by RX/TX checkers.
- One sub-module, rr_pick:
  - Combinational round-robin first-one finder.
  - Inputs: request vector and rr_ptr. Output: one-hot pick plus valid.
- FSM, stall counter and output register stay in tx_frame_sched.

Test Plan:
- Idle fill: no in_vld, out_rdy=1 for 20 cycles after reset -> out_vld=0 on the first cycle, then IDLE_BLK every cycle; grant=0.
- Single frame: req0 sends start(0x78), 8 body blocks, term(0x87) back-to-back -> the same 10 blocks appear 1 cycle later in order, grant=01 for the duration, then IDLE_BLK.
- Round-robin: both requesters hold 10-block frames ready continuously -> frames alternate req0, req1, req0, with no IDLE between frames beyond 1 idle slot at each boundary.
- Backpressure: out_rdy toggles 1,0,1,0 mid-frame -> out_dat is stable while out_rdy=0, and in_rdy[g]=0 in those cycles; no blocks are lost.
- Orphan: req1 sends a body block (sync 01) while in S_IDLE -> it is consumed, err_drop pulses for 1 cycle, and the output stays IDLE_BLK.
- Timeout: req0 sends start plus 2 body blocks, then in_vld=0 for 16 slots -> 16 bubbles, then ERR_BLK with err_timeout=1. The remaining req0 blocks up to term are discarded while IDLE_BLK is output, then req1 gets the next grant.
